// File: rtl/minisys_regfile_sb.sv
// Minisys 32x32 GPR file with WB->ID bypass and a per-register pending-write scoreboard.
// Issue stalls on RAW hazards and on pending-counter saturation.
module minisys_regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned PEND_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_en,
    input  logic              rt_en,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              iss_valid,
    input  logic              iss_dst_en,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec,
    output logic              sb_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [PEND_W-1:0] r_pend [NREGS];
    logic              r_sb_err;

    logic              w_wb_live;
    logic              w_rs_haz;
    logic              w_rt_haz;
    logic              w_dst_sat;
    logic              w_iss_fire;
    logic [NREGS-1:0]  w_inc;
    logic [NREGS-1:0]  w_dec;

    assign w_wb_live = wb_en && (wb_reg != '0);

    always_comb begin
        rs_data = '0;
        if (rs_addr != '0) begin
            rs_data = (wb_en && wb_reg == rs_addr) ? wb_data : r_regs[rs_addr];
        end
        rt_data = '0;
        if (rt_addr != '0) begin
            rt_data = (wb_en && wb_reg == rt_addr) ? wb_data : r_regs[rt_addr];
        end
    end

    // A single outstanding write that retires this cycle is covered by the bypass.
    always_comb begin
        w_rs_haz = 1'b0;
        w_rt_haz = 1'b0;
        if (rs_en && rs_addr != '0) begin
            w_rs_haz = (r_pend[rs_addr] > PEND_ONE) ||
                       (r_pend[rs_addr] == PEND_ONE && !(wb_en && wb_reg == rs_addr));
        end
        if (rt_en && rt_addr != '0) begin
            w_rt_haz = (r_pend[rt_addr] > PEND_ONE) ||
                       (r_pend[rt_addr] == PEND_ONE && !(wb_en && wb_reg == rt_addr));
        end
        w_dst_sat  = iss_dst_en && (iss_dst != '0) && (r_pend[iss_dst] == PEND_MAX);
        stall      = iss_valid && (w_rs_haz || w_rt_haz || w_dst_sat);
        w_iss_fire = iss_valid && !stall;
    end

    always_comb begin
        w_inc    = '0;
        w_dec    = '0;
        busy_vec = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            w_inc[r]    = w_iss_fire && iss_dst_en && (iss_dst == ADDR_W'(r));
            w_dec[r]    = wb_en && (wb_reg == ADDR_W'(r)) && (r_pend[r] != '0);
            busy_vec[r] = (r_pend[r] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
                r_pend[r] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            if (w_wb_live) begin
                r_regs[wb_reg] <= wb_data;
                if (r_pend[wb_reg] == '0) begin
                    r_sb_err <= 1'b1;
                end
            end
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_pend[r] <= r_pend[r] + PEND_ONE;
                end else if (w_dec[r] && !w_inc[r]) begin
                    r_pend[r] <= r_pend[r] - PEND_ONE;
                end
            end
        end
    end

    assign sb_err = r_sb_err;

endmodule

// File: tb/tb_minisys_regfile_sb.sv
// Directed self-checking bench for minisys_regfile_sb.
module tb_minisys_regfile_sb;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_en;
    logic        rt_en;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        iss_valid;
    logic        iss_dst_en;
    logic [4:0]  iss_dst;
    logic        stall;
    logic [31:0] busy_vec;
    logic        sb_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    minisys_regfile_sb dut (
        .clock      (clock),
        .reset      (reset),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_en      (rs_en),
        .rt_en      (rt_en),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .iss_valid  (iss_valid),
        .iss_dst_en (iss_dst_en),
        .iss_dst    (iss_dst),
        .stall      (stall),
        .busy_vec   (busy_vec),
        .sb_err     (sb_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset      = 1'b0;
        wb_en      = 1'b0;
        wb_reg     = '0;
        wb_data    = '0;
        rs_addr    = '0;
        rt_addr    = '0;
        rs_en      = 1'b0;
        rt_en      = 1'b0;
        iss_valid  = 1'b0;
        iss_dst_en = 1'b0;
        iss_dst    = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic issue(input logic [4:0] dst);
        iss_valid  = 1'b1;
        iss_dst_en = 1'b1;
        iss_dst    = dst;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_reg  = r;
        wb_data = d;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        idle();

        // 1) reset state
        rs_addr = 5'd5; rt_addr = 5'd31; rs_en = 1'b1; rt_en = 1'b1; iss_valid = 1'b1;
        settle();
        check("rst_rs", rs_data, 32'h0);
        check("rst_rt", rt_data, 32'h0);
        check("rst_busy", busy_vec, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_err", {31'b0, sb_err}, 32'h0);
        step();

        // 2) bypass then array read
        issue(5'd16);
        settle();
        step();
        wb(5'd16, 32'hDEADBEEF); rs_addr = 5'd16; rt_addr = 5'd16;
        settle();
        check("byp_rs", rs_data, 32'hDEADBEEF);
        check("byp_rt", rt_data, 32'hDEADBEEF);
        step();
        rs_addr = 5'd16;
        settle();
        check("arr_rs", rs_data, 32'hDEADBEEF);
        check("arr_busy", busy_vec, 32'h0);
        step();

        // 3) RAW stall released by same-cycle WB
        issue(5'd8);
        step();
        iss_valid = 1'b1; rs_addr = 5'd8; rs_en = 1'b1;
        settle();
        check("raw_stall", {31'b0, stall}, 32'h1);
        check("raw_busy8", busy_vec, 32'h0000_0100);
        wb(5'd8, 32'hCAFE0008);
        #1;
        check("raw_release", {31'b0, stall}, 32'h0);
        check("raw_byp", rs_data, 32'hCAFE0008);
        step();
        rs_addr = 5'd8;
        settle();
        check("raw_busy_clr", busy_vec, 32'h0);
        check("raw_arr", rs_data, 32'hCAFE0008);
        step();

        // 4) saturation of pend[9]
        for (int i = 0; i < 3; i++) begin
            issue(5'd9);
            settle();
            check("sat_issue", {31'b0, stall}, 32'h0);
            step();
        end
        issue(5'd9);
        settle();
        check("sat_stall", {31'b0, stall}, 32'h1);
        check("sat_busy9", busy_vec, 32'h0000_0200);
        step();
        issue(5'd9); wb(5'd9, 32'h9);
        settle();
        check("sat_wb_nolift", {31'b0, stall}, 32'h1);
        step();
        issue(5'd9); wb(5'd9, 32'h99);
        settle();
        check("pend2_incdec", {31'b0, stall}, 32'h0);
        step();
        iss_valid = 1'b1; rs_addr = 5'd9; rs_en = 1'b1; wb(5'd9, 32'h999);
        settle();
        check("pend2_src", {31'b0, stall}, 32'h1);
        step();
        iss_valid = 1'b1; rs_addr = 5'd9; rs_en = 1'b1; wb(5'd9, 32'h9999);
        settle();
        check("pend1_byp", {31'b0, stall}, 32'h0);
        check("pend1_busy", busy_vec, 32'h0000_0200);
        check("pend1_data", rs_data, 32'h9999);
        step();
        iss_valid = 1'b1; rs_addr = 5'd9; rs_en = 1'b1;
        settle();
        check("pend0_busy", busy_vec, 32'h0);
        check("pend0_stall", {31'b0, stall}, 32'h0);
        check("no_err_yet", {31'b0, sb_err}, 32'h0);
        step();

        // 5) $0 writes and issues ignored
        wb(5'd0, 32'h1234); rs_addr = 5'd0; issue(5'd0);
        settle();
        check("r0_byp", rs_data, 32'h0);
        step();
        rs_addr = 5'd0;
        settle();
        check("r0_read", rs_data, 32'h0);
        check("r0_busy", busy_vec, 32'h0);
        check("r0_err", {31'b0, sb_err}, 32'h0);
        step();

        // 6) underflow, then reset mid-burst
        wb(5'd3, 32'h33);
        step();
        rs_addr = 5'd3;
        settle();
        check("uf_data", rs_data, 32'h33);
        check("uf_err", {31'b0, sb_err}, 32'h1);
        step();
        settle();
        check("uf_err_held", {31'b0, sb_err}, 32'h1);
        step();
        issue(5'd7);
        step();
        issue(5'd7);
        step();
        settle();
        check("pre_rst_busy", busy_vec, 32'h0000_0080);
        iss_valid = 1'b1; rs_addr = 5'd7; rs_en = 1'b1;
        #1;
        check("pre_rst_stall", {31'b0, stall}, 32'h1);
        step();
        reset = 1'b1; issue(5'd7); wb(5'd7, 32'h77);
        step();
        iss_valid = 1'b1; rs_addr = 5'd7; rs_en = 1'b1;
        settle();
        check("post_rst_busy", busy_vec, 32'h0);
        check("post_rst_err", {31'b0, sb_err}, 32'h0);
        check("post_rst_r7", rs_data, 32'h0);
        check("post_rst_stall", {31'b0, stall}, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
